// File: rtl/output_write_arbiter.sv
//==============================================================================
// Module   : output_write_arbiter
// Function : Round-robin arbiter sharing the result RAM write port among M
//            lanes, with a full-RAM clear sweep and write/completion tracking.
//            Optional overwrite detection: OUT_ARB_OVERWRITE_CHECK_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module output_write_arbiter #(
    parameter int R = 8,
    parameter int N = 32,
    parameter int M = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [M-1:0]              req,
    input  logic [M*$clog2(R)-1:0]    idx,
    input  logic [M*N-1:0]            data,
    output logic [M-1:0]              gnt,
    input  logic                      clr_start,
    output logic                      busy,
    output logic                      ram_wr,
    output logic                      ram_rst,
    output logic [$clog2(R)-1:0]      ram_i,
    output logic [N-1:0]              ram_pi,
    output logic                      done,
    output logic [15:0]               wr_count,
    output logic                      err
);

    localparam int AW = $clog2(R);
    localparam int PW = $clog2(M);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_ARB   = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   sweep_q, sweep_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [R-1:0]    bitmap_q, bitmap_d;
    logic [M-1:0]    gnt_q, gnt_d;
    logic            ram_wr_q, ram_wr_d;
    logic            ram_rst_q, ram_rst_d;
    logic [AW-1:0]   ram_i_q, ram_i_d;
    logic [N-1:0]    ram_pi_q, ram_pi_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [15:0]     cnt_q, cnt_d;

    logic [M-1:0]    elig;
    logic            found;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   cand_p;
    int              cand;
    logic [AW-1:0]   sel_idx;
    logic [N-1:0]    sel_data;

    // Last cycle's grantee is masked so a lane cannot be granted twice before it reacts.
    always_comb begin
        elig   = req & ~gnt_q;
        found  = 1'b0;
        sel    = '0;
        cand   = 0;
        cand_p = '0;
        for (int off = 0; off < M; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= M) cand = cand - M;
            cand_p = PW'(cand);
            if (!found && elig[cand_p]) begin
                found = 1'b1;
                sel   = cand_p;
            end
        end
    end

    assign sel_idx  = idx[int'(sel)*AW +: AW];
    assign sel_data = data[int'(sel)*N +: N];

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        ptr_d     = ptr_q;
        bitmap_d  = bitmap_q;
        gnt_d     = '0;
        ram_wr_d  = 1'b0;
        ram_rst_d = 1'b0;
        ram_i_d   = ram_i_q;
        ram_pi_d  = ram_pi_q;
        busy_d    = 1'b0;
        done_d    = done_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_CLEAR: begin
                ram_rst_d = 1'b1;
                ram_i_d   = sweep_q;
                busy_d    = 1'b1;
                sweep_d   = sweep_q + AW'(1);
                bitmap_d  = '0;
                done_d    = 1'b0;
                cnt_d     = '0;
                if (sweep_q == AW'(R-1)) state_d = S_ARB;
            end
            default: begin
                done_d = done_q | (&bitmap_q);
                if (clr_start) begin
                    state_d = S_CLEAR;
                    sweep_d = '0;
                    busy_d  = 1'b1;
                end else if (found) begin
                    gnt_d[sel]        = 1'b1;
                    ram_wr_d          = 1'b1;
                    ram_i_d           = sel_idx;
                    ram_pi_d          = sel_data;
                    ptr_d             = (sel == PW'(M-1)) ? '0 : sel + PW'(1);
                    bitmap_d[sel_idx] = 1'b1;
                    cnt_d             = cnt_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            sweep_q   <= '0;
            ptr_q     <= '0;
            bitmap_q  <= '0;
            gnt_q     <= '0;
            ram_wr_q  <= 1'b0;
            ram_rst_q <= 1'b0;
            ram_i_q   <= '0;
            ram_pi_q  <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            ptr_q     <= ptr_d;
            bitmap_q  <= bitmap_d;
            gnt_q     <= gnt_d;
            ram_wr_q  <= ram_wr_d;
            ram_rst_q <= ram_rst_d;
            ram_i_q   <= ram_i_d;
            ram_pi_q  <= ram_pi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef OUT_ARB_OVERWRITE_CHECK_EN
    logic ovw_q, ovw_d;
    logic err_q;

    // Overwrite is captured at grant time and folded into err one cycle later.
    assign ovw_d = (state_q == S_ARB) && !clr_start && found && bitmap_q[sel_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovw_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ovw_q <= ovw_d;
            err_q <= (state_q == S_CLEAR) ? 1'b0 : (err_q | ovw_q);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign gnt      = gnt_q;
    assign busy     = busy_q;
    assign ram_wr   = ram_wr_q;
    assign ram_rst  = ram_rst_q;
    assign ram_i    = ram_i_q;
    assign ram_pi   = ram_pi_q;
    assign done     = done_q;
    assign wr_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_output_write_arbiter.sv
//==============================================================================
// Module   : tb_output_write_arbiter
// Function : Self-checking bench for output_write_arbiter (table, directed and
//            randomized traffic against a behavioural reference model).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_output_write_arbiter;

    localparam int R  = 8;
    localparam int N  = 32;
    localparam int M  = 4;
    localparam int AW = 3;
`ifdef OUT_ARB_OVERWRITE_CHECK_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [M-1:0]      req;
    logic [M*AW-1:0]   idx;
    logic [M*N-1:0]    data;
    logic              clr_start;
    logic [M-1:0]      gnt;
    logic              busy, ram_wr, ram_rst, done, err;
    logic [AW-1:0]     ram_i;
    logic [N-1:0]      ram_pi;
    logic [15:0]       wr_count;

    always #5 clk = ~clk;

    output_write_arbiter #(.R(R), .N(N), .M(M)) dut (
        .clk(clk), .rst(rst), .req(req), .idx(idx), .data(data), .gnt(gnt),
        .clr_start(clr_start), .busy(busy), .ram_wr(ram_wr), .ram_rst(ram_rst),
        .ram_i(ram_i), .ram_pi(ram_pi), .done(done), .wr_count(wr_count), .err(err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit            m_in_clear = 1'b1;
    int            m_sweep = 0;
    int            m_ptr = 0;
    bit [R-1:0]    m_written = '0;
    bit            m_pend = 1'b0;
    logic [M-1:0]  e_gnt = '0;
    logic          e_wr = 1'b0, e_rst = 1'b0, e_busy = 1'b1, e_done = 1'b0, e_err = 1'b0;
    logic [AW-1:0] e_i = '0;
    logic [N-1:0]  e_pi = '0;
    logic [15:0]   e_cnt = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [M-1:0] prev;
        if (rst) begin
            m_in_clear = 1'b1; m_sweep = 0; m_ptr = 0; m_written = '0; m_pend = 1'b0;
            e_gnt = '0; e_wr = 1'b0; e_rst = 1'b0; e_i = '0; e_pi = '0;
            e_busy = 1'b1; e_done = 1'b0; e_cnt = '0; e_err = 1'b0;
        end else if (m_in_clear) begin
            e_rst = 1'b1; e_i = AW'(m_sweep); e_busy = 1'b1;
            e_gnt = '0; e_wr = 1'b0;
            m_written = '0; e_done = 1'b0; e_cnt = '0; e_err = 1'b0; m_pend = 1'b0;
            m_sweep++;
            if (m_sweep == R) begin
                m_in_clear = 1'b0;
                m_sweep = 0;
            end
        end else begin
            e_rst = 1'b0; e_busy = 1'b0;
            e_done = e_done || (&m_written);
            e_err = e_err || m_pend;
            m_pend = 1'b0;
            prev = e_gnt;
            e_gnt = '0; e_wr = 1'b0;
            if (clr_start) begin
                m_in_clear = 1'b1; m_sweep = 0; e_busy = 1'b1;
            end else begin
                for (int off = 0; off < M; off++) begin
                    int k;
                    int ix;
                    k = (m_ptr + off) % M;
                    if (!e_wr && req[k] && !prev[k]) begin
                        ix = int'(idx[k*AW +: AW]);
                        e_gnt[k] = 1'b1; e_wr = 1'b1;
                        e_i = AW'(ix); e_pi = data[k*N +: N];
                        if (OVW && m_written[ix]) m_pend = 1'b1;
                        m_written[ix] = 1'b1;
                        e_cnt = e_cnt + 16'd1;
                        m_ptr = (k + 1) % M;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("gnt", gnt, e_gnt);
        check("ram_wr", ram_wr, e_wr);
        check("ram_rst", ram_rst, e_rst);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("wr_count", wr_count, e_cnt);
        check("err", err, e_err);
        if (e_wr || e_rst) check("ram_i", ram_i, e_i);
        if (e_wr) check("ram_pi", ram_pi, e_pi);
    endtask

    task automatic set_lane(input int k, input int ix, input logic [N-1:0] d);
        idx[k*AW +: AW] = AW'(ix);
        data[k*N +: N]  = d;
    endtask

    task automatic do_write(input int k, input int ix, input logic [N-1:0] d);
        bit got;
        got = 1'b0;
        set_lane(k, ix, d);
        req[k] = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            if (e_gnt[k]) got = 1'b1;
        end
        if (!got) check("write_timeout", 64'd0, 64'd1);
        req[k] = 1'b0;
    endtask

    typedef struct {
        logic [M-1:0]  req;
        logic [M-1:0]  gnt;
        logic          wr;
        logic [AW-1:0] ri;
        logic [N-1:0]  pi;
        logic [15:0]   cnt;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int g;
        logic prev2;
        tbl[0] = '{req: 4'b1111, gnt: 4'b0001, wr: 1'b1, ri: 3'd0, pi: 32'hA0, cnt: 16'd1};
        tbl[1] = '{req: 4'b1110, gnt: 4'b0010, wr: 1'b1, ri: 3'd1, pi: 32'hA1, cnt: 16'd2};
        tbl[2] = '{req: 4'b1100, gnt: 4'b0100, wr: 1'b1, ri: 3'd2, pi: 32'hA2, cnt: 16'd3};
        tbl[3] = '{req: 4'b1000, gnt: 4'b1000, wr: 1'b1, ri: 3'd3, pi: 32'hA3, cnt: 16'd4};
        tbl[4] = '{req: 4'b0000, gnt: 4'b0000, wr: 1'b0, ri: 3'd0, pi: 32'h0,  cnt: 16'd4};

        rst = 1'b1; req = '0; idx = '0; data = '0; clr_start = 1'b0;

        // Reset and initial sweep
        tick(); tick();
        check("rst_busy", busy, 1'b1);
        rst = 1'b0;
        for (int c = 0; c < R; c++) begin
            tick();
            check("sweep_rst", ram_rst, 1'b1);
            check("sweep_idx", ram_i, c);
            check("sweep_busy", busy, 1'b1);
        end

        // All lanes at once, round-robin from pointer 0
        for (int k = 0; k < M; k++) set_lane(k, k, 32'hA0 + k);
        for (int v = 0; v < 5; v++) begin
            req = tbl[v].req;
            tick();
            check("tbl_busy", busy, 1'b0);
            check("tbl_gnt", gnt, tbl[v].gnt);
            check("tbl_wr", ram_wr, tbl[v].wr);
            check("tbl_cnt", wr_count, tbl[v].cnt);
            if (tbl[v].wr) begin
                check("tbl_ri", ram_i, tbl[v].ri);
                check("tbl_pi", ram_pi, tbl[v].pi);
            end
        end

        // Lane 2 alone holding req: every other cycle
        set_lane(2, 2, 32'h22);
        req = 4'b0100;
        g = 0; prev2 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("lane2_b2b", prev2 & gnt[2], 1'b0);
            prev2 = gnt[2];
            if (gnt[2]) g++;
        end
        check("lane2_grants", g, 5);
        req = '0;
        tick();

        // Fill every entry, then done and clear
        for (int i = 0; i < R; i++) do_write(i % M, i, 32'h100 + i);
        check("done_same", done, 1'b0);
        tick();
        check("done_after", done, 1'b1);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        g = 0;
        for (int c = 0; c < R + 2; c++) begin
            tick();
            if (ram_rst) g++;
        end
        check("clr_len", g, R);
        check("clr_done", done, 1'b0);
        check("clr_cnt", wr_count, 16'd0);

        // Clear while lanes 1 and 3 wait
        set_lane(1, 1, 32'h11);
        set_lane(3, 3, 32'h33);
        req = 4'b1010;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        g = 0;
        for (int c = 0; c < R; c++) begin
            tick();
            if (gnt != '0) g++;
        end
        check("clr_nogrant", g, 0);
        tick();
        check("post_clr_first", gnt, 4'b0010);
        req[1] = 1'b0;
        tick();
        check("post_clr_second", gnt, 4'b1000);
        req[3] = 1'b0;
        tick();

        // Double write to index 5
        do_write(0, 5, 32'h55);
        do_write(1, 5, 32'h56);
        tick();
        check("ovw_err", err, OVW);
        tick(); tick();
        check("ovw_sticky", err, OVW);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            clr_start = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 249) == 0);
            tick();
            for (int k = 0; k < M; k++) begin
                if (e_gnt[k]) begin
                    if ($urandom_range(0, 1) == 1) set_lane(k, $urandom_range(0, R-1), $urandom);
                    else req[k] = 1'b0;
                end else if (!req[k] && $urandom_range(0, 2) == 0) begin
                    set_lane(k, $urandom_range(0, R-1), $urandom);
                    req[k] = 1'b1;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
